// File: rtl/multicycle_control_fsm_pkg.sv
// rtl/multicycle_control_fsm_pkg.sv - shared types and encodings for the multicycle control unit
package multicycle_control_fsm_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
      S_MEMWRITE, S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH
   } state_t;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   function automatic logic cond_ex(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v, res;
      {n, z, c, v} = nzcv;
      case (cond)
         COND_EQ: res = z;
         COND_NE: res = ~z;
         COND_CS: res = c;
         COND_CC: res = ~c;
         COND_MI: res = n;
         COND_PL: res = ~n;
         COND_VS: res = v;
         COND_VC: res = ~v;
         COND_HI: res = c & ~z;
         COND_LS: res = ~c | z;
         COND_GE: res = (n == v);
         COND_LT: res = (n != v);
         COND_GT: res = ~z & (n == v);
         COND_LE: res = z | (n != v);
         COND_AL: res = 1'b1;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/cond_flags_unit.sv
// rtl/cond_flags_unit.sv - NZCV flags register and the condition decision latched at DECODE
module cond_flags_unit
   import multicycle_control_fsm_pkg::*;
#(
   parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [3:0] i_cond,
   input  logic [3:0] i_alu_flags,
   input  logic [1:0] i_flag_w,
   input  logic       i_cond_latch,
   output logic [3:0] o_flags,
   output logic       o_cond_ex_reg
);

   logic [3:0] r_flags;
   logic       r_cond_ex;

   // Flag writes are gated by the decision taken at DECODE, so they never affect it mid-instruction.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_flags   <= FLAGS_RESET;
         r_cond_ex <= 1'b0;
      end else begin
         if (i_cond_latch)
            r_cond_ex <= cond_ex(i_cond, r_flags);
         if (i_flag_w[1] & r_cond_ex)
            r_flags[3:2] <= i_alu_flags[3:2];
         if (i_flag_w[0] & r_cond_ex)
            r_flags[1:0] <= i_alu_flags[1:0];
      end
   end

   assign o_flags       = r_flags;
   assign o_cond_ex_reg = r_cond_ex;

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - Moore control FSM and ALU decoder for the multicycle datapath
module multicycle_control_fsm
   import multicycle_control_fsm_pkg::*;
#(
   parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [3:0] Cond,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [3:0] ALUFlags,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       AdrSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUControl,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc,
   output logic [3:0] Flags
);

   state_t     r_state, w_next;
   logic       w_irw, w_pc_fetch, w_regw, w_memw, w_branch, w_exec, w_cond_latch;
   logic [1:0] w_dec_alu, w_flag_w;
   logic       w_dec_nowrite, w_dec_cv, w_supported, w_no_write, w_pcs, w_cex;
   logic [3:0] w_cmd;

   always_ff @(posedge CLK) begin
      if (RESET) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next       = S_FETCH;
      w_irw        = 1'b0;
      w_pc_fetch   = 1'b0;
      w_regw       = 1'b0;
      w_memw       = 1'b0;
      w_branch     = 1'b0;
      w_exec       = 1'b0;
      w_cond_latch = 1'b0;
      AdrSrc       = 1'b0;
      ALUSrcA      = 1'b0;
      ALUSrcB      = SRCB_REG;
      ResultSrc    = RES_ALUOUT;
      case (r_state)
         S_FETCH: begin
            w_irw      = 1'b1;
            w_pc_fetch = 1'b1;
            ALUSrcA    = 1'b1;
            ALUSrcB    = SRCB_FOUR;
            ResultSrc  = RES_ALURES;
            w_next     = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcA      = 1'b1;
            ALUSrcB      = SRCB_FOUR;
            w_cond_latch = 1'b1;
            case (Op)
               OP_MEM:  w_next = S_MEMADR;
               OP_DP:   w_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
               OP_BR:   w_next = S_BRANCH;
               default: w_next = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            ALUSrcB = SRCB_IMM;
            w_next  = Funct[0] ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
            w_next = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc = RES_RDATA;
            w_regw    = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc = 1'b1;
            w_memw = 1'b1;
         end
         S_EXECUTER: begin
            w_exec = 1'b1;
            w_next = S_ALUWB;
         end
         S_EXECUTEI: begin
            ALUSrcB = SRCB_IMM;
            w_exec  = 1'b1;
            w_next  = S_ALUWB;
         end
         S_ALUWB:  w_regw = 1'b1;
         S_BRANCH: begin
            ALUSrcB   = SRCB_IMM;
            ResultSrc = RES_ALURES;
            w_branch  = 1'b1;
         end
         default: w_next = S_FETCH;
      endcase
   end

   assign w_cmd = Funct[4:1];

   always_comb begin
      w_dec_alu     = ALU_ADD;
      w_dec_nowrite = 1'b1;
      w_dec_cv      = 1'b0;
      w_supported   = 1'b1;
      case (w_cmd)
         CMD_ADD: begin w_dec_nowrite = 1'b0; w_dec_cv = 1'b1; end
         CMD_SUB: begin w_dec_alu = ALU_SUB; w_dec_nowrite = 1'b0; w_dec_cv = 1'b1; end
         CMD_AND: begin w_dec_alu = ALU_AND; w_dec_nowrite = 1'b0; end
         CMD_ORR: begin w_dec_alu = ALU_ORR; w_dec_nowrite = 1'b0; end
         CMD_CMP: begin w_dec_alu = ALU_SUB; w_dec_cv = 1'b1; end
         default: w_supported = 1'b0;
      endcase
   end

   // Decoder results only matter for data-processing; memory Funct bits must not suppress LDR writeback.
   assign ALUControl = w_exec ? w_dec_alu : ALU_ADD;
   assign w_flag_w   = w_exec ? {Funct[0] & w_supported, Funct[0] & w_dec_cv} : 2'b00;
   assign w_no_write = (Op == OP_DP) & w_dec_nowrite;

   cond_flags_unit #(.FLAGS_RESET(FLAGS_RESET)) u_cond_flags (
      .i_clk         (CLK),
      .i_reset       (RESET),
      .i_cond        (Cond),
      .i_alu_flags   (ALUFlags),
      .i_flag_w      (w_flag_w),
      .i_cond_latch  (w_cond_latch),
      .o_flags       (Flags),
      .o_cond_ex_reg (w_cex)
   );

   assign w_pcs     = w_branch | (w_regw & (Rd == 4'd15));
   assign IRWrite   = ~RESET & w_irw;
   assign PCWrite   = ~RESET & (w_pc_fetch | (w_pcs & w_cex));
   assign RegWrite  = ~RESET & w_regw & w_cex & ~w_no_write;
   assign MemWrite  = ~RESET & w_memw & w_cex;
   assign ImmSrc    = Op;
   assign RegSrc    = {(Op == OP_MEM) & ~Funct[0], Op == OP_BR};

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Control unit that sequences the shared ARM-subset datapath (one memory, one ALU) over multiple cycles per instruction. It replaces the single-cycle decoder with a Moore state machine, a registered condition decision and an NZCV flags register. It sits between the instruction register fields and the datapath mux selects and write enables.

Parameters:
FLAGS_RESET, 4'b0000, NZCV value loaded on reset.

Ports:
CLK  in  1  clock; all state updates on the rising edge
RESET  in  1  synchronous, active-high reset
Cond  in  4  Instr[31:28]
Op  in  2  Instr[27:26]; 00 data-proc, 01 memory, 10 branch, 11 illegal
Funct  in  6  Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S (data-proc) or L (memory)
Rd  in  4  Instr[15:12]
ALUFlags  in  4  NZCV from the ALU in the current cycle
IRWrite  out  1  load instruction register
PCWrite  out  1  load PC
RegWrite  out  1  register file write
MemWrite  out  1  memory write
AdrSrc  out  1  0=PC, 1=ALUOut
ALUSrcA  out  1  0=reg A, 1=PC
ALUSrcB  out  2  00=reg B, 01=ExtImm, 10=constant 4
ResultSrc  out  2  00=ALUOut, 01=read data, 10=ALUResult
ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
ImmSrc  out  2  equals Op
RegSrc  out  2  [0]=Op==10, [1]=Op==01 and not L
Flags  out  4  current NZCV register (debug)

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH. On reset: state=FETCH, Flags=FLAGS_RESET, CondExReg=0.
- While RESET=1, IRWrite, PCWrite, RegWrite and MemWrite are forced to 0.
- Default per state: all enables 0, selects 00.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALU ADD, ResultSrc=10, PCWrite=1. Next state is DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ALU ADD. CondExReg <= CondEx(Cond, Flags). Next state depends on Op:
  - 01 -> MEMADR.
  - 00 with I=1 -> EXECUTEI; 00 with I=0 -> EXECUTER.
  - 10 -> BRANCH.
  - 11 -> FETCH, with no writes.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALU ADD. Next state is MEMREAD if L=1, else MEMWRITE.
- MEMREAD: AdrSrc=1. Next state is MEMWB.
- MEMWB: ResultSrc=01, RegW. Next state is FETCH.
- MEMWRITE: AdrSrc=1, MemW. Next state is FETCH.
- EXECUTER: ALUSrcA=0, ALUSrcB=00, decoded ALU op, FlagW. Next state is ALUWB.
- EXECUTEI: as EXECUTER but ALUSrcB=01. Next state is ALUWB.
- ALUWB: ResultSrc=00, RegW unless NoWrite. Next state is FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ALU ADD, ResultSrc=10, Branch. Next state is FETCH.
- cmd decode:
  - 0100 -> ADD.
  - 0010 -> SUB.
  - 0000 -> AND.
  - 1100 -> ORR.
  - 1010 (CMP) -> SUB with NoWrite=1.
  - Any other cmd -> ADD with NoWrite=1 and FlagW=00.
- FlagW[1] (NZ) = S. FlagW[0] (CV) = S and cmd is ADD, SUB or CMP.
- Gating: RegWrite = RegW & CondExReg & ~NoWrite. MemWrite = MemW & CondExReg.
- Flags update: Flags[3:2] <= ALUFlags[3:2] when FlagW[1] & CondExReg; Flags[1:0] <= ALUFlags[1:0] when FlagW[0] & CondExReg. Updates occur only at the edge ending an EXECUTE state.
- PCS = Branch | (RegW & Rd==15). Outside FETCH, PCWrite = PCS & CondExReg.
- CondEx by Cond:
  - EQ Z, NE ~Z.
  - CS C, CC ~C.
  - MI N, PL ~N.
  - VS V, VC ~V.
  - HI C&~Z, LS ~C|Z.
  - GE N==V, LT N!=V.
  - GT ~Z&(N==V), LE Z|(N!=V).
  - AL 1; 1111 -> 0.
- The condition decision is frozen at DECODE. A flag update in EXECUTE does not alter the same instruction's writeback.
- Latency in cycles: LDR 5; STR 4; data-proc 4; branch 3; illegal 2.
- Asserting RESET in any state returns to FETCH on the next edge. No partial write occurs in the reset cycle.

Decomposition:
- Shared package holds:
  - the state enum;
  - ALUControl codes;
  - Op codes;
  - Cond codes;
  - select encodings (ALUSrcB, ResultSrc).
- One sub-module, cond_flags_unit: Flags register, CondEx logic, CondExReg.
- The FSM and the ALU decoder stay in the top module.

Test Plan:
- ADD R1,R2,#5 (Cond=1110, Op=00, Funct=101000, Rd=1) -> states FETCH, DECODE, EXECUTEI, ALUWB. ALUControl=00 and ALUSrcB=01 in cycle 3; RegWrite=1 only in cycle 4.
- LDR (Op=01, Funct=011001), then STR (Funct=011000) -> LDR takes 5 cycles, RegWrite=1 in MEMWB with ResultSrc=01. STR takes 4 cycles, MemWrite=1 in MEMWRITE with AdrSrc=1, RegSrc=10.
- SUBS with ALUFlags=0100 (Funct=000101), then BEQ (Cond=0000, Op=10) -> Flags=0100 after EXECUTER. BRANCH asserts PCWrite=1 with ImmSrc=10.
- BNE with Flags Z=1 -> BRANCH state entered but PCWrite=0. Same check with an ADDNE: RegWrite=0.
- CMP (Funct=010101) -> Flags update, RegWrite=0 in ALUWB. MOV-type unsupported cmd 1101 -> no RegWrite, Flags unchanged.
- RESET asserted during MEMWRITE -> MemWrite=0 in that cycle; FETCH next cycle; Flags=0000, IRWrite=1 after release.
